control_sequencer: RTL

//  Microcode sequencer for the 8-bit bus CPU. Steps a fetch/execute T-state counter.

---
 rtl/control_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Fetch/execute microcode sequencer: T-state counter plus decoded control word for the bus CPU.
// Latency: ctrl_word is combinational from the current T-state; t_state/halted update on each rising edge.
// Backpressure: none; it advances every clock and freezes only after HLT until reset.
module control_sequencer #(
  parameter int T_LAST   = 4,
  parameter int CW_WIDTH = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          opcode,
  input  logic                flag_z,
  output logic [CW_WIDTH-1:0] ctrl_word,
  output logic [2:0]          t_state,
  output logic                halted
);

  typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} tstate_e;

  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JZ  = 4'b0111;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [CW_WIDTH-1:0] CW_IDLE    = 14'h1DFE;
  localparam logic [CW_WIDTH-1:0] CW_FETCH0  = 14'h1DF4;
  localparam logic [CW_WIDTH-1:0] CW_FETCH1  = 14'h1DCF;
  localparam logic [CW_WIDTH-1:0] CW_IR_MAR  = 14'h1DB6;
  localparam logic [CW_WIDTH-1:0] CW_IR_PC   = 14'h1DBA;
  localparam logic [CW_WIDTH-1:0] CW_RAM_A   = 14'h1D6E;
  localparam logic [CW_WIDTH-1:0] CW_RAM_B   = 14'h15EE;
  localparam logic [CW_WIDTH-1:0] CW_ALU_ADD = 14'h197E;
  localparam logic [CW_WIDTH-1:0] CW_ALU_SUB = 14'h1B7E;
  localparam logic [CW_WIDTH-1:0] CW_OUT     = 14'h0CFE;
  localparam logic [CW_WIDTH-1:0] CW_HALT    = 14'h3DFE;

  tstate_e               state_q, state_d;
  logic                  halted_q, halted_d;
  logic [CW_WIDTH-1:0]   word;
  logic                  has_exec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= T0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // The IR is still loading during T1, so the NOP cut-off uses whatever opcode is presented then.
  assign has_exec = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_JMP) || (opcode == OP_JZ)  || (opcode == OP_OUT) ||
                    (opcode == OP_HLT);

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    word     = CW_IDLE;
    if (halted_q) begin
      word = CW_HALT;
    end else begin
      case (state_q)
        T0: begin
          word    = CW_FETCH0;
          state_d = T1;
        end
        T1: begin
          word    = CW_FETCH1;
          state_d = has_exec ? T2 : T0;
        end
        T2: begin
          state_d = T0;
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              word    = CW_IR_MAR;
              state_d = T3;
            end
            OP_JMP: word = CW_IR_PC;
            OP_JZ:  word = flag_z ? CW_IR_PC : CW_IDLE;
            OP_OUT: word = CW_OUT;
            OP_HLT: begin
              word     = CW_HALT;
              halted_d = 1'b1;
              state_d  = T2;
            end
            default: word = CW_IDLE;
          endcase
        end
        T3: begin
          state_d = T0;
          if (opcode == OP_LDA) begin
            word = CW_RAM_A;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            word    = CW_RAM_B;
            state_d = T4;
          end
        end
        T4: begin
          state_d = T0;
          if (opcode == OP_ADD) word = CW_ALU_ADD;
          else if (opcode == OP_SUB) word = CW_ALU_SUB;
        end
        default: state_d = T0;
      endcase
      if (state_q == tstate_e'(3'(T_LAST)) && !halted_d) state_d = T0;
    end
  end

  assign ctrl_word = rst_n ? word : CW_IDLE;
  assign t_state   = state_q;
  assign halted    = halted_q;

  // Only one driver may own the bus: at most one active-low enable asserted.
  assert property (@(posedge clk) disable iff (!rst_n)
    $countones(~{ctrl_word[1], ctrl_word[4], ctrl_word[6], ctrl_word[8], ctrl_word[10]}) <= 1);

endmodule
